// File: rtl/lsu_tlb_wr_fmt_pkg.sv
// Shared definitions for the DTLB write-format path: STLB field positions,
// ASI write-type encodings, controller states and parity helpers.
package lsu_tlb_wr_fmt_pkg;

  localparam int STLB_TAG_W          = 59;
  localparam int STLB_TAG_V          = 58;
  localparam int STLB_TAG_SZ0        = 57;
  localparam int STLB_TAG_NFO        = 56;
  localparam int STLB_TAG_IE         = 55;
  localparam int STLB_TAG_U          = 54;
  localparam int STLB_TAG_VA_47_28_HI = 53;
  localparam int STLB_TAG_VA_47_28_LO = 34;
  localparam int STLB_TAG_VA_27_22_HI = 33;
  localparam int STLB_TAG_VA_27_22_LO = 28;
  localparam int STLB_TAG_VA_27_22_V  = 27;
  localparam int STLB_TAG_VA_21_16_V  = 25;
  localparam int STLB_TAG_VA_21_16_HI = 23;
  localparam int STLB_TAG_VA_21_16_LO = 18;
  localparam int STLB_TAG_VA_15_13_V  = 16;
  localparam int STLB_TAG_VA_15_13_HI = 15;
  localparam int STLB_TAG_VA_15_13_LO = 13;
  localparam int STLB_TAG_CTX_HI      = 12;
  localparam int STLB_TAG_CTX_LO      = 0;
  // Bits 54 (U), 26 and 24 are outside tag parity coverage.
  localparam logic [58:0] STLB_TAG_PAR_MASK = 59'h7BF_FFFF_FAFF_FFFF;

  localparam int STLB_DATA_W         = 43;
  localparam int STLB_DATA_PARITY    = 42;
  localparam int STLB_DATA_NFO       = 41;
  localparam int STLB_DATA_IE        = 40;
  localparam int STLB_DATA_PA_HI     = 38;
  localparam int STLB_DATA_PA_LO     = 12;
  localparam int STLB_DATA_SEL2      = 11;
  localparam int STLB_DATA_SEL1      = 10;
  localparam int STLB_DATA_SEL0      = 9;
  localparam int STLB_DATA_ATTR_HI   = 5;
  localparam int STLB_DATA_ATTR_LO   = 0;

  typedef enum logic [1:0] {
    ASI_WR_TAGACC  = 2'b00,
    ASI_WR_DATAIN  = 2'b01,
    ASI_WR_DATAACC = 2'b10,
    ASI_WR_RSVD    = 2'b11
  } asi_wr_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wr_state_e;

  function automatic logic stlb_tag_parity(input logic [58:0] tag);
    return ^(tag & STLB_TAG_PAR_MASK);
  endfunction

  function automatic logic stlb_data_parity(input logic [41:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/lsu_tlb_wr_fmt_if.sv
// ASI store request bus and DTLB write request bus between the LSU and DTLB.
interface lsu_tlb_wr_fmt_if
  import lsu_tlb_wr_fmt_pkg::*;
#(
  parameter int TIDW = 2
);
  logic                   asi_wr_vld;
  logic [1:0]             asi_wr_type;
  logic [TIDW-1:0]        asi_wr_tid;
  logic [5:0]             asi_wr_idx;
  logic [63:0]            asi_wr_data;
  logic                   tlb_wr_ack;
  logic                   tlb_wr_vld;
  logic                   tlb_wr_idx_vld;
  logic [5:0]             tlb_wr_idx;
  logic [STLB_TAG_W-1:0]  tlb_wr_tte_tag;
  logic [STLB_DATA_W-1:0] tlb_wr_tte_data;
  logic                   tlb_wr_tte_tag_parity;
  logic                   tlb_wr_tte_data_parity;
  logic                   lsu_tlbwr_busy;
  logic                   lsu_tlbwr_sz_err;
  logic                   lsu_tlbwr_ovf;

  modport master (
    output asi_wr_vld, asi_wr_type, asi_wr_tid, asi_wr_idx, asi_wr_data, tlb_wr_ack,
    input  tlb_wr_vld, tlb_wr_idx_vld, tlb_wr_idx, tlb_wr_tte_tag, tlb_wr_tte_data,
           tlb_wr_tte_tag_parity, tlb_wr_tte_data_parity, lsu_tlbwr_busy,
           lsu_tlbwr_sz_err, lsu_tlbwr_ovf
  );

  modport slave (
    input  asi_wr_vld, asi_wr_type, asi_wr_tid, asi_wr_idx, asi_wr_data, tlb_wr_ack,
    output tlb_wr_vld, tlb_wr_idx_vld, tlb_wr_idx, tlb_wr_tte_tag, tlb_wr_tte_data,
           tlb_wr_tte_tag_parity, tlb_wr_tte_data_parity, lsu_tlbwr_busy,
           lsu_tlbwr_sz_err, lsu_tlbwr_ovf
  );
endinterface

// File: rtl/lsu_tlb_wr_fmt_enc.sv
// Combinational TTE-to-STLB formatter: page-size decode, tag/data packing, parity.
module lsu_tlb_wr_fmt_enc
  import lsu_tlb_wr_fmt_pkg::*;
(
  input  logic [47:0]            tagacc,
  input  logic [63:0]            wr_data,
  output logic                   sz_ok,
  output logic [STLB_TAG_W-1:0]  tag,
  output logic [STLB_DATA_W-1:0] data,
  output logic                   tag_par,
  output logic                   data_par
);
  logic [2:0] sz;
  logic [2:0] sel;
  logic       unused_data_bits;

  assign sz = {wr_data[48], wr_data[62:61]};
  assign unused_data_bits = ^{wr_data[58:49], wr_data[47:40], wr_data[12:7], wr_data[0]};

  // Only 8K/64K/4M/256M pages exist in the STLB; sel marks which VA chunks are masked.
  always_comb begin
    sel   = 3'b000;
    sz_ok = 1'b1;
    case (sz)
      3'b000:  sel = 3'b000;
      3'b001:  sel = 3'b001;
      3'b011:  sel = 3'b011;
      3'b101:  sel = 3'b111;
      default: begin
        sel   = 3'b000;
        sz_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    tag = 59'h0;
    tag[STLB_TAG_V]   = wr_data[63];
    tag[STLB_TAG_SZ0] = wr_data[61];
    tag[STLB_TAG_NFO] = wr_data[60];
    tag[STLB_TAG_IE]  = wr_data[59];
    tag[STLB_TAG_U]   = 1'b0;
    tag[STLB_TAG_VA_47_28_HI:STLB_TAG_VA_47_28_LO] = tagacc[47:28];
    tag[STLB_TAG_VA_27_22_HI:STLB_TAG_VA_27_22_LO] = tagacc[27:22];
    tag[STLB_TAG_VA_21_16_HI:STLB_TAG_VA_21_16_LO] = tagacc[21:16];
    tag[STLB_TAG_VA_15_13_HI:STLB_TAG_VA_15_13_LO] = tagacc[15:13];
    tag[STLB_TAG_CTX_HI:STLB_TAG_CTX_LO]           = tagacc[12:0];
    tag[STLB_TAG_VA_27_22_V] = ~sel[2];
    tag[STLB_TAG_VA_21_16_V] = ~sel[1];
    tag[STLB_TAG_VA_15_13_V] = ~sel[0];
  end

  always_comb begin
    data = 43'h0;
    data[STLB_DATA_PARITY] = 1'b0;
    data[STLB_DATA_NFO]    = wr_data[60];
    data[STLB_DATA_IE]     = wr_data[59];
    data[STLB_DATA_PA_HI:STLB_DATA_PA_LO]     = wr_data[39:13];
    data[STLB_DATA_SEL2]   = sel[2];
    data[STLB_DATA_SEL1]   = sel[1];
    data[STLB_DATA_SEL0]   = sel[0];
    data[STLB_DATA_ATTR_HI:STLB_DATA_ATTR_LO] = wr_data[6:1];
  end

  assign tag_par  = stlb_tag_parity(tag);
  assign data_par = stlb_data_parity(data[41:0]);

endmodule

// File: rtl/lsu_tlb_wr_fmt.sv
// DTLB write-side controller: per-thread Tag Access registers, IDLE/PEND
// request controller and the registered TLB write request outputs.
module lsu_tlb_wr_fmt
  import lsu_tlb_wr_fmt_pkg::*;
#(
  parameter int NTHR = 4,
  parameter int TIDW = 2
)(
  input  logic                    rclk,
  input  logic                    rst_l,
  lsu_tlb_wr_fmt_if.slave         wr
);
  wr_state_e               state_q, state_d;
  logic [47:0]             tagacc_q [NTHR];
  logic [47:0]             tagacc_d [NTHR];
  logic                    vld_q, vld_d;
  logic                    idx_vld_q, idx_vld_d;
  logic [5:0]              idx_q, idx_d;
  logic [STLB_TAG_W-1:0]   tag_q, tag_d;
  logic [STLB_DATA_W-1:0]  data_q, data_d;
  logic                    tpar_q, tpar_d;
  logic                    dpar_q, dpar_d;
  logic                    sz_err_q, sz_err_d;
  logic                    ovf_q, ovf_d;

  logic                    is_tagacc;
  logic                    is_tlb_st;
  logic                    enc_sz_ok;
  logic [STLB_TAG_W-1:0]   enc_tag;
  logic [STLB_DATA_W-1:0]  enc_data;
  logic                    enc_tpar;
  logic                    enc_dpar;

  assign is_tagacc = wr.asi_wr_vld && (wr.asi_wr_type == ASI_WR_TAGACC);
  assign is_tlb_st = wr.asi_wr_vld && ((wr.asi_wr_type == ASI_WR_DATAIN) ||
                                       (wr.asi_wr_type == ASI_WR_DATAACC));

  lsu_tlb_wr_fmt_enc u_enc (
    .tagacc   (tagacc_q[wr.asi_wr_tid]),
    .wr_data  (wr.asi_wr_data),
    .sz_ok    (enc_sz_ok),
    .tag      (enc_tag),
    .data     (enc_data),
    .tag_par  (enc_tpar),
    .data_par (enc_dpar)
  );

  // Next-state: Tag Access updates are independent of the write controller.
  always_comb begin
    state_d   = state_q;
    tagacc_d  = tagacc_q;
    idx_vld_d = idx_vld_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    data_d    = data_q;
    tpar_d    = tpar_q;
    dpar_d    = dpar_q;
    sz_err_d  = 1'b0;
    ovf_d     = 1'b0;

    if (is_tagacc) begin
      tagacc_d[wr.asi_wr_tid] = wr.asi_wr_data[47:0];
    end else begin
      tagacc_d = tagacc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (is_tlb_st && enc_sz_ok) begin
          state_d   = ST_PEND;
          idx_vld_d = (wr.asi_wr_type == ASI_WR_DATAACC);
          idx_d     = wr.asi_wr_idx;
          tag_d     = enc_tag;
          data_d    = enc_data;
          tpar_d    = enc_tpar;
          dpar_d    = enc_dpar;
        end else if (is_tlb_st) begin
          sz_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        // A store coinciding with the ack is still dropped: one idle cycle is guaranteed.
        ovf_d = is_tlb_st;
        if (wr.tlb_wr_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vld_d = (state_d == ST_PEND);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NTHR; i++) begin
        tagacc_q[i] <= 48'h0;
      end
      vld_q     <= 1'b0;
      idx_vld_q <= 1'b0;
      idx_q     <= 6'h0;
      tag_q     <= 59'h0;
      data_q    <= 43'h0;
      tpar_q    <= 1'b0;
      dpar_q    <= 1'b0;
      sz_err_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tagacc_q  <= tagacc_d;
      vld_q     <= vld_d;
      idx_vld_q <= idx_vld_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      tpar_q    <= tpar_d;
      dpar_q    <= dpar_d;
      sz_err_q  <= sz_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr.tlb_wr_vld             = vld_q;
  assign wr.lsu_tlbwr_busy         = vld_q;
  assign wr.tlb_wr_idx_vld         = idx_vld_q;
  assign wr.tlb_wr_idx             = idx_q;
  assign wr.tlb_wr_tte_tag         = tag_q;
  assign wr.tlb_wr_tte_data        = data_q;
  assign wr.tlb_wr_tte_tag_parity  = tpar_q;
  assign wr.tlb_wr_tte_data_parity = dpar_q;
  assign wr.lsu_tlbwr_sz_err       = sz_err_q;
  assign wr.lsu_tlbwr_ovf          = ovf_q;

endmodule

// File: tb/tb_lsu_tlb_wr_fmt.sv
// Self-checking bench for lsu_tlb_wr_fmt: directed scenarios plus randomized
// traffic compared against a transaction-level model of the write path.
module tb_lsu_tlb_wr_fmt;
  logic rclk = 1'b0;
  logic rst_l;
  always #5 rclk = ~rclk;

  lsu_tlb_wr_fmt_if #(.TIDW(2)) bus ();
  lsu_tlb_wr_fmt #(.NTHR(4), .TIDW(2)) dut (.rclk(rclk), .rst_l(rst_l), .wr(bus.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_tagacc [4];
  logic        m_pend, m_idx_vld, m_ovf, m_szerr;
  logic [5:0]  m_idx;
  logic [58:0] m_tag;
  logic [42:0] m_data;

  // Page-size table: returns 1 if supported, with the VA-chunk mask selects.
  function automatic bit page_sel(input logic [63:0] d, output logic [2:0] sel);
    sel = 3'b000;
    case ({d[48], d[62:61]})
      3'd0:    sel = 3'b000;
      3'd1:    sel = 3'b001;
      3'd3:    sel = 3'b011;
      3'd5:    sel = 3'b111;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [58:0] exp_tag(input logic [63:0] ta, input logic [63:0] d);
    logic [2:0] sel;
    void'(page_sel(d, sel));
    return {d[63], d[61], d[60], d[59], 1'b0, ta[47:28], ta[27:22], ~sel[2], 1'b0,
            ~sel[1], 1'b0, ta[21:16], 1'b0, ~sel[0], ta[15:13], ta[12:0]};
  endfunction

  function automatic logic [42:0] exp_data(input logic [63:0] d);
    logic [2:0] sel;
    void'(page_sel(d, sel));
    return {1'b0, d[60], d[59], 1'b0, d[39:13], sel, 3'b000, d[6:1]};
  endfunction

  function automatic logic tag_par(input logic [58:0] t);
    int c;
    c = $countones({t[58:55], t[53:27], t[25], t[23:0]});
    return c[0];
  endfunction

  function automatic logic data_par(input logic [42:0] d);
    int c;
    c = $countones(d[41:0]);
    return c[0];
  endfunction

  function automatic logic [63:0] make_data(input logic [2:0] sz);
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    d[48] = sz[2];
    d[62:61] = sz[1:0];
    return d;
  endfunction

  task automatic model_step();
    logic       was_pend;
    logic [2:0] sel;
    bit         st;
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) m_tagacc[i] = 64'h0;
      m_pend = 1'b0; m_idx_vld = 1'b0; m_idx = 6'h0; m_tag = 59'h0;
      m_data = 43'h0; m_ovf = 1'b0; m_szerr = 1'b0;
      return;
    end
    was_pend = m_pend;
    m_ovf = 1'b0;
    m_szerr = 1'b0;
    st = bus.asi_wr_vld && (bus.asi_wr_type == 2'b01 || bus.asi_wr_type == 2'b10);
    if (bus.asi_wr_vld && bus.asi_wr_type == 2'b00) m_tagacc[bus.asi_wr_tid] = bus.asi_wr_data;
    if (st && was_pend) m_ovf = 1'b1;
    else if (st && !page_sel(bus.asi_wr_data, sel)) m_szerr = 1'b1;
    else if (st) begin
      m_pend    = 1'b1;
      m_idx_vld = (bus.asi_wr_type == 2'b10);
      m_idx     = bus.asi_wr_idx;
      m_tag     = exp_tag(m_tagacc[bus.asi_wr_tid], bus.asi_wr_data);
      m_data    = exp_data(bus.asi_wr_data);
    end
    if (was_pend && bus.tlb_wr_ack) m_pend = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.asi_wr_vld = 1'b0; bus.asi_wr_type = 2'b00; bus.asi_wr_tid = 2'd0;
    bus.asi_wr_idx = 6'd0; bus.asi_wr_data = 64'h0; bus.tlb_wr_ack = 1'b0;
  endtask

  task automatic drive_st(input logic [1:0] t, input logic [1:0] tid, input logic [5:0] idx,
                          input logic [63:0] d);
    bus.asi_wr_vld = 1'b1; bus.asi_wr_type = t; bus.asi_wr_tid = tid;
    bus.asi_wr_idx = idx; bus.asi_wr_data = d;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    idle_inputs();
    cycle(); cycle();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_idx_vld, bus.tlb_wr_idx,
         bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data, bus.tlb_wr_tte_tag_parity,
         bus.tlb_wr_tte_data_parity, bus.lsu_tlbwr_sz_err, bus.lsu_tlbwr_ovf} !== 115'h0) begin
      n_errors++; $display("FAIL reset_outputs: got nonzero, expected all 0");
    end
    rst_l = 1'b1;
    cycle();
    n_checks++;
    if (bus.tlb_wr_vld !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_vld: got %b expected 0", bus.tlb_wr_vld);
    end
  endtask

  task automatic test_datain_basic();
    drive_st(2'b00, 2'd1, 6'd0, 64'h0000_1234_5678_A005);
    cycle();
    drive_st(2'b01, 2'd1, 6'd9, 64'h8000_0012_3456_6006);
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_idx_vld} !== 3'b110) begin
      n_errors++; $display("FAIL din_vld_busy_idxvld: got %b expected 110",
                           {bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_idx_vld});
    end
    n_checks++;
    if (bus.tlb_wr_tte_tag !== m_tag) begin
      n_errors++; $display("FAIL din_tag: got %h expected %h", bus.tlb_wr_tte_tag, m_tag);
    end
    n_checks++;
    if (bus.tlb_wr_tte_data !== m_data) begin
      n_errors++; $display("FAIL din_data: got %h expected %h", bus.tlb_wr_tte_data, m_data);
    end
    n_checks++;
    if ({bus.tlb_wr_tte_tag[12:0], bus.tlb_wr_tte_tag[27], bus.tlb_wr_tte_tag[25],
         bus.tlb_wr_tte_tag[16], bus.tlb_wr_tte_data[11:9]} !== {13'h005, 3'b111, 3'b000}) begin
      n_errors++; $display("FAIL din_ctx_sel: got ctx %h vbits %b sel %b expected 005 111 000",
                           bus.tlb_wr_tte_tag[12:0],
                           {bus.tlb_wr_tte_tag[27], bus.tlb_wr_tte_tag[25], bus.tlb_wr_tte_tag[16]},
                           bus.tlb_wr_tte_data[11:9]);
    end
    n_checks++;
    if ({bus.tlb_wr_tte_tag_parity, bus.tlb_wr_tte_data_parity} !==
        {tag_par(m_tag), data_par(m_data)}) begin
      n_errors++; $display("FAIL din_parity: got %b expected %b",
                           {bus.tlb_wr_tte_tag_parity, bus.tlb_wr_tte_data_parity},
                           {tag_par(m_tag), data_par(m_data)});
    end
    bus.tlb_wr_ack = 1'b1;
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy} !== 2'b00) begin
      n_errors++; $display("FAIL din_ack_clear: got %b expected 00",
                           {bus.tlb_wr_vld, bus.lsu_tlbwr_busy});
    end
  endtask

  task automatic test_dataaccess_256m();
    drive_st(2'b00, 2'd2, 6'd0, {$urandom(), $urandom()});
    cycle();
    drive_st(2'b10, 2'd2, 6'd37, make_data(3'b101));
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.tlb_wr_idx_vld, bus.tlb_wr_idx} !== {1'b1, 1'b1, 6'd37}) begin
      n_errors++; $display("FAIL dacc_idx: got vld %b idx_vld %b idx %0d expected 1 1 37",
                           bus.tlb_wr_vld, bus.tlb_wr_idx_vld, bus.tlb_wr_idx);
    end
    n_checks++;
    if ({bus.tlb_wr_tte_data[11:9], bus.tlb_wr_tte_tag[27], bus.tlb_wr_tte_tag[25],
         bus.tlb_wr_tte_tag[16]} !== 6'b111_000) begin
      n_errors++; $display("FAIL dacc_256m_sel: got %b expected 111000",
                           {bus.tlb_wr_tte_data[11:9], bus.tlb_wr_tte_tag[27],
                            bus.tlb_wr_tte_tag[25], bus.tlb_wr_tte_tag[16]});
    end
    n_checks++;
    if ({bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data} !== {m_tag, m_data}) begin
      n_errors++; $display("FAIL dacc_tag_data: got %h/%h expected %h/%h",
                           bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data, m_tag, m_data);
    end
  endtask

  task automatic test_hold_and_ack();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_idx, bus.tlb_wr_tte_tag,
           bus.tlb_wr_tte_data} !== {2'b11, m_idx, m_tag, m_data}) begin
        n_errors++; $display("FAIL hold_stable[%0d]: got vld %b tag %h expected vld 1 tag %h",
                             i, bus.tlb_wr_vld, bus.tlb_wr_tte_tag, m_tag);
      end
    end
    bus.tlb_wr_ack = 1'b1;
    drive_st(2'b01, 2'd0, 6'd1, make_data(3'b001));
    cycle();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.lsu_tlbwr_ovf} !== 3'b001) begin
      n_errors++; $display("FAIL ack_coincident: got vld/busy/ovf %b expected 001",
                           {bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.lsu_tlbwr_ovf});
    end
    bus.tlb_wr_ack = 1'b0;
    drive_st(2'b01, 2'd0, 6'd1, make_data(3'b011));
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_ovf, bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data} !==
        {2'b10, m_tag, m_data}) begin
      n_errors++; $display("FAIL accept_after_ack: got vld %b ovf %b tag %h expected 1 0 %h",
                           bus.tlb_wr_vld, bus.lsu_tlbwr_ovf, bus.tlb_wr_tte_tag, m_tag);
    end
  endtask

  task automatic test_overflow();
    logic [58:0] held_tag;
    held_tag = m_tag;
    drive_st(2'b01, 2'd0, 6'd5, make_data(3'b000));
    cycle();
    n_checks++;
    if ({bus.lsu_tlbwr_ovf, bus.tlb_wr_vld, bus.tlb_wr_tte_tag} !== {2'b11, held_tag}) begin
      n_errors++; $display("FAIL ovf_busy: got ovf %b vld %b tag %h expected 1 1 %h",
                           bus.lsu_tlbwr_ovf, bus.tlb_wr_vld, bus.tlb_wr_tte_tag, held_tag);
    end
    drive_st(2'b00, 2'd0, 6'd0, {$urandom(), $urandom()});
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.lsu_tlbwr_ovf, bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data} !== {1'b0, held_tag, m_data}) begin
      n_errors++; $display("FAIL tagacc_while_pend: got ovf %b tag %h expected 0 %h",
                           bus.lsu_tlbwr_ovf, bus.tlb_wr_tte_tag, held_tag);
    end
    bus.tlb_wr_ack = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic test_sz_err();
    logic [2:0] bad [4];
    bad = '{3'b010, 3'b100, 3'b110, 3'b111};
    for (int i = 0; i < 4; i++) begin
      drive_st(2'b01, 2'($urandom_range(3)), 6'd0, make_data(bad[i]));
      cycle();
      idle_inputs();
      n_checks++;
      if ({bus.lsu_tlbwr_sz_err, bus.tlb_wr_vld} !== 2'b10) begin
        n_errors++; $display("FAIL sz_err[%0d]: got sz_err/vld %b expected 10", i,
                             {bus.lsu_tlbwr_sz_err, bus.tlb_wr_vld});
      end
      cycle();
      n_checks++;
      if ({bus.lsu_tlbwr_sz_err, bus.tlb_wr_vld} !== 2'b00) begin
        n_errors++; $display("FAIL sz_err_pulse[%0d]: got %b expected 00", i,
                             {bus.lsu_tlbwr_sz_err, bus.tlb_wr_vld});
      end
    end
    drive_st(2'b11, 2'd1, 6'd3, make_data(3'b000));
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_sz_err, bus.lsu_tlbwr_ovf} !== 3'b000) begin
      n_errors++; $display("FAIL rsvd_type: got %b expected 000",
                           {bus.tlb_wr_vld, bus.lsu_tlbwr_sz_err, bus.lsu_tlbwr_ovf});
    end
  endtask

  task automatic test_random();
    logic [2:0] szs [8];
    szs = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b000, 3'b101, 3'b010, 3'b111};
    for (int i = 0; i < 400; i++) begin
      bus.asi_wr_vld  = ($urandom_range(9) < 6);
      bus.asi_wr_type = 2'($urandom_range(3));
      bus.asi_wr_tid  = 2'($urandom_range(3));
      bus.asi_wr_idx  = 6'($urandom_range(63));
      bus.asi_wr_data = make_data(szs[$urandom_range(7)]);
      bus.tlb_wr_ack  = ($urandom_range(9) < 3);
      cycle();
      n_checks++;
      if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.lsu_tlbwr_ovf, bus.lsu_tlbwr_sz_err,
           bus.tlb_wr_idx_vld} !== {m_pend, m_pend, m_ovf, m_szerr, m_idx_vld}) begin
        n_errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i,
                             {bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.lsu_tlbwr_ovf,
                              bus.lsu_tlbwr_sz_err, bus.tlb_wr_idx_vld},
                             {m_pend, m_pend, m_ovf, m_szerr, m_idx_vld});
      end
      n_checks++;
      if ({bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data, bus.tlb_wr_tte_tag_parity,
           bus.tlb_wr_tte_data_parity} !== {m_tag, m_data, tag_par(m_tag), data_par(m_data)}) begin
        n_errors++; $display("FAIL rand_tte[%0d]: got %h/%h/%b%b expected %h/%h/%b%b", i,
                             bus.tlb_wr_tte_tag, bus.tlb_wr_tte_data, bus.tlb_wr_tte_tag_parity,
                             bus.tlb_wr_tte_data_parity, m_tag, m_data, tag_par(m_tag),
                             data_par(m_data));
      end
      if (m_idx_vld) begin
        n_checks++;
        if (bus.tlb_wr_idx !== m_idx) begin
          n_errors++; $display("FAIL rand_idx[%0d]: got %0d expected %0d", i, bus.tlb_wr_idx, m_idx);
        end
      end
    end
    idle_inputs();
    bus.tlb_wr_ack = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    drive_st(2'b00, 2'd3, 6'd0, {$urandom(), $urandom()});
    cycle();
    drive_st(2'b01, 2'd3, 6'd0, make_data(3'b001));
    cycle();
    idle_inputs();
    rst_l = 1'b0;
    cycle();
    rst_l = 1'b1;
    n_checks++;
    if ({bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_tte_tag} !== {2'b00, 59'h0}) begin
      n_errors++; $display("FAIL reset_mid: got vld %b busy %b tag %h expected 0 0 0",
                           bus.tlb_wr_vld, bus.lsu_tlbwr_busy, bus.tlb_wr_tte_tag);
    end
    drive_st(2'b01, 2'd3, 6'd0, make_data(3'b000));
    cycle();
    idle_inputs();
    n_checks++;
    if ({bus.tlb_wr_vld, bus.tlb_wr_tte_tag[53:28], bus.tlb_wr_tte_tag[23:18],
         bus.tlb_wr_tte_tag[15:0] & 16'h7FFF} !== {1'b1, 26'h0, 6'h0, 16'h0}) begin
      n_errors++; $display("FAIL reset_tagacc_cleared: got tag %h expected VA/ctx 0",
                           bus.tlb_wr_tte_tag);
    end
    n_checks++;
    if (bus.tlb_wr_tte_tag !== m_tag) begin
      n_errors++; $display("FAIL reset_tag_model: got %h expected %h", bus.tlb_wr_tte_tag, m_tag);
    end
    bus.tlb_wr_ack = 1'b1;
    cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_datain_basic();
    test_dataaccess_256m();
    test_hold_and_ack();
    test_overflow();
    test_sz_err();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_tlb_wr_fmt.md
Name: lsu_tlb_wr_fmt

Overview:
- Write-side datapath and controller for the DTLB. It is the converse of the TLB read-format path.
- Accepts ASI stores to the per-thread Tag Access register and to the Data-In / Data-Access registers.
- Converts architectural 64-bit TTE tag/data into the internal STLB tag (59b) and data (43b) formats, with page-size mux selects and parity.
- Issues one TLB write at a time over a valid/ack handshake. Sits between the LSU ASI store pipe and the DTLB array.

Parameters:
- NTHR, 4, number of strands with a private Tag Access register
- TIDW, 2, thread-id width (clog2 NTHR)

Ports:
- rclk  in  1  clock; all state on rising edge
- rst_l  in  1  synchronous active-low reset
- asi_wr_vld  in  1  ASI store to a TLB register this cycle
- asi_wr_type  in  2  00 TagAccess, 01 DataIn, 10 DataAccess, 11 reserved (ignored)
- asi_wr_tid  in  TIDW  issuing thread
- asi_wr_idx  in  6  entry index for DataAccess
- asi_wr_data  in  64  store data
- tlb_wr_ack  in  1  DTLB accepted the presented write
- tlb_wr_vld  out  1  write request pending
- tlb_wr_idx_vld  out  1  1 = indexed write (DataAccess), 0 = replacement write (DataIn)
- tlb_wr_idx  out  6  entry index
- tlb_wr_tte_tag  out  59  formatted STLB tag
- tlb_wr_tte_data  out  43  formatted STLB data
- tlb_wr_tte_tag_parity  out  1  even-parity bit over tag
- tlb_wr_tte_data_parity  out  1  even-parity bit over data
- lsu_tlbwr_busy  out  1  write pending; ASI pipe must hold DataIn/DataAccess stores
- lsu_tlbwr_sz_err  out  1  one-cycle pulse: unsupported page size, write dropped
- lsu_tlbwr_ovf  out  1  one-cycle pulse: DataIn/DataAccess store arrived while busy, dropped

Behaviour:
- Reset (rst_l=0 at an edge): all outputs 0. Tag Access registers cleared. Any pending write is abandoned with no ack required. tlb_wr_vld is 0 on the first cycle after reset deasserts.
- TagAccess write (type 00): tagacc[tid] <= {data[63:13] VA, data[12:0] ctx} next edge. No TLB transaction. Allowed while busy.
- DataIn/DataAccess write (type 01/10) accepted only when not busy:
  - Page size sz = {data[48], data[62:61]}.
  - 000 8K gives sel{2,1,0}=000; 001 64K gives 001; 011 4M gives 011; 101 256M gives 111.
  - Any other sz: write dropped, sz_err pulses the next cycle, state unchanged.
- Tag format, built from tagacc[tid] at acceptance:
  - V = data[63], U = 0.
  - VA 47:28, 27:22, 21:16, 15:13 and ctx 12:0 copied from tagacc.
  - VA_27_22_V = ~sel2, VA_21_16_V = ~sel1, VA_15_13_V = ~sel0.
  - Tag bits 58:55 = data[63], data[61], data[60], data[59].
  - Masked VA bits are written as captured (the array ignores them).
- Data format: PA 39:13 = data[39:13]; L, CP, CV, E, P, W = data[6:1]; NFO = data[60]; IE = data[59]; sel bits as above. Data parity field bit = 0.
- Field positions: STLB_TAG_* / STLB_DATA_* constants only.
- Parity:
  - tag parity = XOR of tag[58:55], tag[53:27], tag[25], tag[23:0].
  - data parity = XOR of data[41:0].
  - Both are computed on the formatted, registered values.
- Handshake and latency:
  - Store accepted in cycle N: all tlb_wr_* outputs are registered and valid from N+1.
  - tlb_wr_vld and busy are held stable until the edge where tlb_wr_ack=1. Both are 0 the next cycle.
  - A new DataIn/DataAccess store is accepted no earlier than the cycle after ack (1 idle cycle minimum).
- tlb_wr_ack while tlb_wr_vld=0 is ignored.
- Write while busy: dropped, ovf pulses N+1, pending request unchanged.
- TagAccess to the same tid while a write is pending does not alter the pending tag.
- Simultaneous ack and new store in the same cycle: the store is dropped (ovf pulses).
- Type 11: ignored, no pulse.

Decomposition:
- lsu.h: STLB_TAG_* / STLB_DATA_* field macros and the ASI write-type encodings.
- Sub-module lsu_tlb_wr_enc: combinational page-size decode, tag/data packing and parity.
- Top level holds the Tag Access register file, the IDLE/PEND controller and the output registers.

Test Plan:
- TagAccess tid1 VA=0x0000_1234_5678_A000 ctx=0x005, then DataIn tid1 sz=000 PA=0x12_3456_6000 W=1 P=1 -> tlb_wr_vld at N+1; idx_vld=0; sel=000; VA fields and ctx=0x005 packed; tag/data parity match XOR model.
- DataAccess idx=37 sz=101 (256M) -> sel=111; all three VA-valid bits 0; idx=37, idx_vld=1.
- Ack held low 5 cycles -> vld, busy and all outputs stable; ack on cycle 6 -> vld=0 next cycle; new DataIn accepted only from the following cycle.
- DataIn while busy and DataIn coincident with ack -> ovf pulses one cycle each; pending tag/data unchanged.
- sz=010 -> sz_err one-cycle pulse; no vld.
- rst_l=0 mid-pending -> next cycle vld=0, busy=0, tagacc cleared; a later DataIn issues tag VA=0, ctx=0.
